data_mem_responder: RTL and testbench

//  Responder end of the processor data-memory interface. Accepts load/store

---
 rtl/data_mem_responder_pkg.sv | 39 +++
 rtl/data_mem_responder_dmem_array.sv | 53 +++++
 rtl/data_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared definitions for the data-memory responder and its word array.
//   - state_e          : responder FSM states (S_IDLE, S_WAIT, S_RESP)
//   - DMEM_READ/WRITE  : encodings of the DataMem_RW request bit
//   - DMEM_DATA_WIDTH  : data/address width (fixed at 32, four byte lanes)
//   - isMisaligned()   : alignment rule used when DMEM_ALIGN_CHECK_EN is set
// ---------------------------------------------------------------------------
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic DMEM_READ  = 1'b0;
  localparam logic DMEM_WRITE = 1'b1;

  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_LANES      = DMEM_DATA_WIDTH / 8;

  // A full-word access must sit on a word boundary; a half-word access
  // (either half selected) must sit on a half-word boundary. Other lane
  // patterns, including single bytes, are never flagged.
  function automatic logic isMisaligned(input logic [1:0] addrLow,
                                        input logic [3:0] select);
    logic bad;
    bad = 1'b0;
    if ((select == 4'b1111) && (addrLow != 2'b00)) begin
      bad = 1'b1;
    end
    if (((select == 4'b0011) || (select == 4'b1100)) && addrLow[0]) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
//   Synchronous single-port word RAM with one write enable per byte lane.
//   Reads are registered: rdata_o updates on the edge where re_i is high and
//   holds until the next read. Contents are never cleared.
//   Ports:
//     clk      in  clock
//     we_i     in  write strobe (qualified by be_i)
//     re_i     in  read strobe
//     be_i     in  byte-lane enables, bit i = bits [8i+7:8i]
//     idx_i    in  word index
//     wdata_i  in  lane-aligned write data
//     rdata_o  out registered read data
// ---------------------------------------------------------------------------
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic                       re_i,
  input  logic [DMEM_LANES-1:0]      be_i,
  input  logic [IDX_W-1:0]           idx_i,
  input  logic [DMEM_DATA_WIDTH-1:0] wdata_i,
  output logic [DMEM_DATA_WIDTH-1:0] rdata_o
);

  logic [DMEM_DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DMEM_DATA_WIDTH-1:0] rdata_q;

  // Byte-lane write port; unselected lanes keep their old contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int lane = 0; lane < DMEM_LANES; lane++) begin
        if (be_i[lane]) begin
          mem[idx_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
        end
      end
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Responder end of the processor data-memory interface. A request seen in
//   IDLE is latched, held for WAIT_CYCLES wait states, then performed on the
//   edge that enters RESP; RESP drives a one-cycle DataMem_Ready pulse.
//   Optional feature macro: DMEM_ALIGN_CHECK_EN (alignment error checking).
//   Ports:
//     clk              in   clock, rising edge
//     rst              in   synchronous active-high reset
//     DataMem_access   in   request valid
//     DataMem_RW       in   1 = write, 0 = read
//     DataMem_Select   in   byte-lane enables
//     DataMem_Address  in   byte address (wraps modulo DEPTH_WORDS*4)
//     WriteDataMem     in   lane-aligned store data
//     ReadDataMem      out  load data, non-zero only in a read Ready cycle
//     DataMem_Ready    out  one-cycle completion pulse
//     DataMem_Err      out  alignment error, coincident with Ready
// ---------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DataMem_access,
  input  logic                  DataMem_RW,
  input  logic [3:0]            DataMem_Select,
  input  logic [DATA_WIDTH-1:0] DataMem_Address,
  input  logic [DATA_WIDTH-1:0] WriteDataMem,
  output logic [DATA_WIDTH-1:0] ReadDataMem,
  output logic                  DataMem_Ready,
  output logic                  DataMem_Err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e                state_q, state_d;
  logic [3:0]            count_q, count_d;
  logic                  rw_q;
  logic [3:0]            sel_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  misaligned_q;

  logic                  accept;
  logic                  enterResp;
  logic                  opRw;
  logic [3:0]            opSel;
  logic [DATA_WIDTH-1:0] opAddr;
  logic [DATA_WIDTH-1:0] opWdata;
  logic                  reqMisaligned;
  logic                  opMisaligned;
  logic                  ramWe;
  logic                  ramRe;
  logic [DATA_WIDTH-1:0] ramRdata;
  logic                  unusedAddrBits;

  assign accept = (state_q == S_IDLE) && DataMem_access;

  // Alignment of the request currently on the inputs; latched on accept so
  // the flag is available through WAIT and RESP.
`ifdef DMEM_ALIGN_CHECK_EN
  assign reqMisaligned = isMisaligned(DataMem_Address[1:0], DataMem_Select);
`else
  assign reqMisaligned = 1'b0;
`endif

  // With zero wait states the operation happens on the same edge that
  // accepts the request, before the latches hold it, so the operand source
  // is the live inputs while in IDLE and the latched copy otherwise.
  always_comb begin
    opRw         = rw_q;
    opSel        = sel_q;
    opAddr       = addr_q;
    opWdata      = wdata_q;
    opMisaligned = misaligned_q;
    if (state_q == S_IDLE) begin
      opRw         = DataMem_RW;
      opSel        = DataMem_Select;
      opAddr       = DataMem_Address;
      opWdata      = WriteDataMem;
      opMisaligned = reqMisaligned;
    end
  end

  // Next-state logic: IDLE -> WAIT -> RESP -> IDLE, WAIT skipped when there
  // are no wait states. The counter is loaded with WAIT_CYCLES on accept and
  // the transition to RESP is taken from the cycle it holds 1.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (DataMem_access) begin
          count_d = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (count_q <= 4'd1) begin
          state_d = S_RESP;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and request latches. Reset aborts whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= 4'd0;
      rw_q         <= DMEM_READ;
      sel_q        <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        rw_q         <= DataMem_RW;
        sel_q        <= DataMem_Select;
        addr_q       <= DataMem_Address;
        wdata_q      <= WriteDataMem;
        misaligned_q <= reqMisaligned;
      end
    end
  end

  // The memory operation fires only on the edge entering RESP; gating with
  // rst makes a reset in the last WAIT cycle drop the pending write.
  assign enterResp = (state_d == S_RESP) && (state_q != S_RESP) && !rst;
  assign ramWe     = enterResp && (opRw == DMEM_WRITE) && !opMisaligned;
  assign ramRe     = enterResp && (opRw == DMEM_READ);

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (ramWe),
    .re_i    (ramRe),
    .be_i    (opSel),
    .idx_i   (opAddr[2 +: IDX_W]),
    .wdata_i (opWdata),
    .rdata_o (ramRdata)
  );

  // Address bits above the index select nothing (addresses alias), and the
  // low two bits only matter to the optional alignment check.
  assign unusedAddrBits = ^{opAddr[DATA_WIDTH-1:IDX_W+2], opAddr[1:0]};

  // The RAM's registered read word is exposed only during a good read
  // response; everywhere else the bus reads as zero.
  assign DataMem_Ready = (state_q == S_RESP);
  assign DataMem_Err   = (state_q == S_RESP) && misaligned_q;
  assign ReadDataMem   = ((state_q == S_RESP) && (rw_q == DMEM_READ) && !misaligned_q)
                         ? ramRdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Three instances share clock and
//   reset: index 0 has WAIT_CYCLES=0, index 1 has 2 (main), index 2 has 3.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        access [3];
  logic        rw     [3];
  logic [3:0]  sel    [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];
  logic        ready  [3];
  logic        err    [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .DataMem_access(access[0]), .DataMem_RW(rw[0]),
    .DataMem_Select(sel[0]), .DataMem_Address(addr[0]), .WriteDataMem(wdata[0]),
    .ReadDataMem(rdata[0]), .DataMem_Ready(ready[0]), .DataMem_Err(err[0]));

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .DataMem_access(access[1]), .DataMem_RW(rw[1]),
    .DataMem_Select(sel[1]), .DataMem_Address(addr[1]), .WriteDataMem(wdata[1]),
    .ReadDataMem(rdata[1]), .DataMem_Ready(ready[1]), .DataMem_Err(err[1]));

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .DataMem_access(access[2]), .DataMem_RW(rw[2]),
    .DataMem_Select(sel[2]), .DataMem_Address(addr[2]), .WriteDataMem(wdata[2]),
    .ReadDataMem(rdata[2]), .DataMem_Ready(ready[2]), .DataMem_Err(err[2]));

  function automatic int waitsOf(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request on instance d, waits (bounded) for Ready, checks the
  // latency and that Ready is a single-cycle pulse, and returns the response.
  task automatic applyStimulus(input int d, input logic w, input logic [3:0] s,
                               input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] rd, output logic e);
    int lat;
    access[d] = 1'b1;
    rw[d]     = w;
    sel[d]    = s;
    addr[d]   = a;
    wdata[d]  = wd;
    @(posedge clk); #1;
    lat = 1;
    while ((ready[d] !== 1'b1) && (lat < 40)) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata[d];
    e  = err[d];
    checkOutput($sformatf("latency_dut%0d", d), 32'(lat), 32'(waitsOf(d) + 1));
    if (w) checkOutput($sformatf("write_rdata_zero_dut%0d", d), rdata[d], 32'h0);
    access[d] = 1'b0;
    @(posedge clk); #1;
    checkOutput($sformatf("ready_single_pulse_dut%0d", d), {31'd0, ready[d]}, 32'h0);
    checkOutput($sformatf("rdata_after_ready_dut%0d", d), rdata[d], 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      access[d] = 1'b0;
      rw[d]     = 1'b0;
      sel[d]    = 4'h0;
      addr[d]   = 32'h0;
      wdata[d]  = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", {31'd0, ready[1]}, 32'h0);
    checkOutput("reset_rdata", rdata[1], 32'h0);
    checkOutput("reset_err",   {31'd0, err[1]},   32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-word write then read back.
    applyStimulus(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, e);
    applyStimulus(1, 1'b0, 4'hF, 32'h10, 32'h0, rd, e);
    checkOutput("read_0x10", rd, 32'hDEADBEEF);
    checkOutput("read_0x10_err", {31'd0, e}, 32'h0);

    // Reads ignore Select.
    applyStimulus(1, 1'b0, 4'h1, 32'h10, 32'h0, rd, e);
    checkOutput("read_ignores_select", rd, 32'hDEADBEEF);

    // Single-lane write merges into the existing word.
    applyStimulus(1, 1'b1, 4'hF, 32'h20, 32'h11223344, rd, e);
    applyStimulus(1, 1'b1, 4'h1, 32'h20, 32'h000000AA, rd, e);
    applyStimulus(1, 1'b0, 4'hF, 32'h20, 32'h0, rd, e);
    checkOutput("byte_lane_write", rd, 32'h112233AA);

    // Upper-half write.
    applyStimulus(1, 1'b1, 4'hC, 32'h20, 32'h5566FFFF, rd, e);
    applyStimulus(1, 1'b0, 4'hF, 32'h20, 32'h0, rd, e);
    checkOutput("half_lane_write", rd, 32'h556633AA);

    // Empty select changes nothing but still completes.
    applyStimulus(1, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, e);
    applyStimulus(1, 1'b0, 4'hF, 32'h20, 32'h0, rd, e);
    checkOutput("select_zero_write", rd, 32'h556633AA);

    // Address 0x1000 aliases word 0.
    applyStimulus(1, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, rd, e);
    applyStimulus(1, 1'b0, 4'hF, 32'h0000, 32'h0, rd, e);
    checkOutput("alias_0x1000", rd, 32'hCAFEF00D);

    // Reset in the last WAIT cycle of a write aborts it.
    applyStimulus(1, 1'b1, 4'hF, 32'h40, 32'h0, rd, e);
    access[1] = 1'b1;
    rw[1]     = 1'b1;
    sel[1]    = 4'hF;
    addr[1]   = 32'h40;
    wdata[1]  = 32'h55AA55AA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_no_ready", {31'd0, ready[1]}, 32'h0);
    access[1] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_no_ready_late", {31'd0, ready[1]}, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 4'hF, 32'h40, 32'h0, rd, e);
    checkOutput("abort_word_unchanged", rd, 32'h0);

    // Misaligned full-word write.
    applyStimulus(1, 1'b1, 4'hF, 32'h42, 32'h12345678, rd, e);
`ifdef DMEM_ALIGN_CHECK_EN
    checkOutput("misaligned_err", {31'd0, e}, 32'h1);
    applyStimulus(1, 1'b0, 4'hF, 32'h40, 32'h0, rd, e);
    checkOutput("misaligned_word", rd, 32'h0);
    applyStimulus(1, 1'b0, 4'hF, 32'h42, 32'h0, rd, e);
    checkOutput("misaligned_read_data", rd, 32'h0);
    checkOutput("misaligned_read_err", {31'd0, e}, 32'h1);
`else
    checkOutput("misaligned_err", {31'd0, e}, 32'h0);
    applyStimulus(1, 1'b0, 4'hF, 32'h40, 32'h0, rd, e);
    checkOutput("misaligned_word", rd, 32'h12345678);
`endif

    // Zero wait states.
    applyStimulus(0, 1'b1, 4'hF, 32'h80, 32'hA5A5F00F, rd, e);
    applyStimulus(0, 1'b0, 4'hF, 32'h80, 32'h0, rd, e);
    checkOutput("w0_read", rd, 32'hA5A5F00F);
    applyStimulus(0, 1'b1, 4'h2, 32'h80, 32'h00007700, rd, e);
    applyStimulus(0, 1'b0, 4'hF, 32'h80, 32'h0, rd, e);
    checkOutput("w0_lane_write", rd, 32'hA5A5770F);

    // Three wait states.
    applyStimulus(2, 1'b1, 4'hF, 32'h84, 32'h0BADC0DE, rd, e);
    applyStimulus(2, 1'b0, 4'hF, 32'h84, 32'h0, rd, e);
    checkOutput("w3_read", rd, 32'h0BADC0DE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
